// File: rtl/decoder_pkg.sv
// Shared definitions for the keypad decoder path: FSM encoding, digit geometry
// and the seconds-tens limit used for time validation.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CAPTURE      = 2'd1,
    WAIT_RELEASE = 2'd2,
    REARM        = 2'd3
  } state_t;

  localparam int NUM_KEYS   = 10;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int BCD_W      = NUM_DIGITS * DIGIT_W;
  localparam int COUNT_W    = 3;

  localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/key_encoder_10to4.sv
// Combinational 10-line one-hot to BCD encoder; o_onehot_ok flags exactly one
// pressed key, otherwise o_code is meaningless.
module key_encoder_10to4
  import decoder_pkg::*;
(
  input  logic [NUM_KEYS-1:0] i_keys,
  output logic [DIGIT_W-1:0]  o_code,
  output logic                o_onehot_ok
);

  logic [3:0] w_hits;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_code = '0;
    w_hits = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (i_keys[i]) begin
        o_code = DIGIT_W'(i);
        w_hits = w_hits + 4'd1;
      end
    end
    o_onehot_ok = (w_hits == 4'd1);
  end

endmodule

// File: rtl/keypad_time_entry.sv
// Captures debounced keypad digits into an MM:SS BCD shift buffer and re-arms
// the debouncer with a one-cycle loadn pulse once all keys have been released.
module keypad_time_entry
  import decoder_pkg::*;
#(
  parameter int RELEASE_CYCLES = 4,
  parameter int REL_W          = 3
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                debounced,
  input  logic                load_en,
  input  logic                clear,
  output logic                loadn,
  output logic [BCD_W-1:0]    bcd_time,
  output logic [COUNT_W-1:0]  digit_count,
  output logic                key_strobe,
  output logic                key_error,
  output logic                time_valid
);

  state_t               r_state;
  state_t               w_state_next;
  logic [REL_W-1:0]     r_rel_cnt;
  logic [REL_W-1:0]     w_rel_cnt_next;
  logic [BCD_W-1:0]     r_bcd_time;
  logic [BCD_W-1:0]     w_bcd_next;
  logic [COUNT_W-1:0]   r_digit_count;
  logic [COUNT_W-1:0]   w_count_next;
  logic                 r_loadn;
  logic                 r_key_strobe;
  logic                 r_key_error;
  logic                 r_time_valid;
  logic                 w_strobe_next;
  logic                 w_error_next;
  logic                 w_accept;
  logic                 w_loadn_next;
  logic                 w_valid_next;
  logic [DIGIT_W-1:0]   w_code;
  logic                 w_onehot_ok;

  key_encoder_10to4 u_encoder (
    .i_keys      (keypad),
    .o_code      (w_code),
    .o_onehot_ok (w_onehot_ok)
  );

  always_comb begin
    w_state_next   = r_state;
    w_rel_cnt_next = '0;
    w_accept       = 1'b0;
    w_error_next   = 1'b0;

    case (r_state)
      IDLE: begin
        if (debounced) w_state_next = CAPTURE;
      end
      CAPTURE: begin
        w_state_next = WAIT_RELEASE;
        if (!w_onehot_ok)
          w_error_next = 1'b1;
        else if (load_en && (r_digit_count < COUNT_W'(NUM_DIGITS)))
          w_accept = 1'b1;
      end
      WAIT_RELEASE: begin
        // The counter is compared after it has been registered, so loadn
        // lands RELEASE_CYCLES+1 cycles after the first released cycle.
        if (r_rel_cnt == REL_W'(RELEASE_CYCLES))
          w_state_next = REARM;
        else if (keypad == '0)
          w_rel_cnt_next = r_rel_cnt + 1'b1;
      end
      REARM: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_bcd_next    = r_bcd_time;
    w_count_next  = r_digit_count;
    w_strobe_next = 1'b0;

    if (w_accept) begin
      w_bcd_next    = {r_bcd_time[BCD_W-DIGIT_W-1:0], w_code};
      w_count_next  = r_digit_count + 1'b1;
      w_strobe_next = 1'b1;
    end

    // Clear overrides a coincident accept, including its strobe.
    if (clear) begin
      w_bcd_next    = '0;
      w_count_next  = '0;
      w_strobe_next = 1'b0;
    end

    w_valid_next = (w_count_next != '0) &&
                   (w_bcd_next[2*DIGIT_W-1:DIGIT_W] <= MAX_SEC_TENS);
    w_loadn_next = (w_state_next == REARM);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state       <= IDLE;
      r_rel_cnt     <= '0;
      r_bcd_time    <= '0;
      r_digit_count <= '0;
      r_loadn       <= 1'b0;
      r_key_strobe  <= 1'b0;
      r_key_error   <= 1'b0;
      r_time_valid  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rel_cnt     <= w_rel_cnt_next;
      r_bcd_time    <= w_bcd_next;
      r_digit_count <= w_count_next;
      r_loadn       <= w_loadn_next;
      r_key_strobe  <= w_strobe_next;
      r_key_error   <= w_error_next;
      r_time_valid  <= w_valid_next;
    end
  end

  assign loadn       = r_loadn;
  assign bcd_time    = r_bcd_time;
  assign digit_count = r_digit_count;
  assign key_strobe  = r_key_strobe;
  assign key_error   = r_key_error;
  assign time_valid  = r_time_valid;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry: digit entry, saturation, key errors,
// seconds validation, clear, load_en gating, bouncing release and mid-run reset.
module tb_keypad_time_entry;

  logic        clk;
  logic        rst;
  logic [9:0]  keypad;
  logic        debounced;
  logic        load_en;
  logic        clear;
  logic        loadn;
  logic [15:0] bcd_time;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic        key_error;
  logic        time_valid;

  int n_pass;
  int n_total;

  keypad_time_entry #(.RELEASE_CYCLES(4), .REL_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .keypad      (keypad),
    .debounced   (debounced),
    .load_en     (load_en),
    .clear       (clear),
    .loadn       (loadn),
    .bcd_time    (bcd_time),
    .digit_count (digit_count),
    .key_strobe  (key_strobe),
    .key_error   (key_error),
    .time_valid  (time_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press a key pattern for 'hold' cycles, then release for 12 cycles, with an
  // optional single bounce at release step bounce_at; counts output pulses.
  task automatic press(input logic [9:0] keys, input int hold, input int bounce_at,
                       output int ns, output int ne, output int nl, output int lat);
    ns = 0; ne = 0; nl = 0; lat = 0;
    keypad    = keys;
    debounced = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      ns += int'(key_strobe); ne += int'(key_error); nl += int'(loadn);
    end
    debounced = 1'b0;
    for (int i = 0; i < 12; i++) begin
      keypad = (i == bounce_at) ? ((keys == '0) ? 10'h001 : keys) : 10'h000;
      step();
      ns += int'(key_strobe); ne += int'(key_error); nl += int'(loadn);
      if (loadn === 1'b1 && lat == 0) lat = i + 1;
    end
    keypad = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_total++; if (bcd_time !== 16'h0000) $display("FAIL reset_bcd: got %h want 0000", bcd_time); else n_pass++;
    n_total++; if (digit_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", digit_count); else n_pass++;
    n_total++; if ({loadn, key_strobe, key_error, time_valid} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {loadn, key_strobe, key_error, time_valid}); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_key();
    int ns, ne, nl, lat;
    press(10'h080, 5, -1, ns, ne, nl, lat);
    n_total++; if (bcd_time !== 16'h0007) $display("FAIL key7_bcd: got %h want 0007", bcd_time); else n_pass++;
    n_total++; if (digit_count !== 3'd1) $display("FAIL key7_count: got %0d want 1", digit_count); else n_pass++;
    n_total++; if (ns != 1) $display("FAIL key7_strobes: got %0d want 1", ns); else n_pass++;
    n_total++; if (ne != 0) $display("FAIL key7_errors: got %0d want 0", ne); else n_pass++;
    n_total++; if (nl != 1) $display("FAIL key7_loadn_pulses: got %0d want 1", nl); else n_pass++;
    n_total++; if (lat != 5) $display("FAIL key7_loadn_latency: got %0d want 5", lat); else n_pass++;
    n_total++; if (time_valid !== 1'b1) $display("FAIL key7_valid: got %b want 1", time_valid); else n_pass++;
  endtask

  task automatic test_full_entry();
    int ns, ne, nl, lat;
    int total_strobes;
    logic [9:0] keys [4];
    keys[0] = 10'h002; keys[1] = 10'h008; keys[2] = 10'h001; keys[3] = 10'h001;
    do_clear();
    total_strobes = 0;
    for (int k = 0; k < 4; k++) begin
      press(keys[k], 3, -1, ns, ne, nl, lat);
      total_strobes += ns;
    end
    n_total++; if (bcd_time !== 16'h1300) $display("FAIL entry_bcd: got %h want 1300", bcd_time); else n_pass++;
    n_total++; if (digit_count !== 3'd4) $display("FAIL entry_count: got %0d want 4", digit_count); else n_pass++;
    n_total++; if (total_strobes != 4) $display("FAIL entry_strobes: got %0d want 4", total_strobes); else n_pass++;
    n_total++; if (time_valid !== 1'b1) $display("FAIL entry_valid: got %b want 1", time_valid); else n_pass++;
    press(10'h200, 3, -1, ns, ne, nl, lat);
    n_total++; if (bcd_time !== 16'h1300) $display("FAIL fifth_bcd: got %h want 1300", bcd_time); else n_pass++;
    n_total++; if (digit_count !== 3'd4) $display("FAIL fifth_count: got %0d want 4", digit_count); else n_pass++;
    n_total++; if (ns != 0 || ne != 0) $display("FAIL fifth_pulses: got strobe %0d error %0d want 0 0", ns, ne); else n_pass++;
    n_total++; if (nl != 1) $display("FAIL fifth_loadn: got %0d want 1", nl); else n_pass++;
  endtask

  task automatic test_key_error();
    int ns, ne, nl, lat;
    press(10'h006, 3, -1, ns, ne, nl, lat);
    n_total++; if (ne != 1) $display("FAIL multi_error: got %0d want 1", ne); else n_pass++;
    n_total++; if (ns != 0) $display("FAIL multi_strobe: got %0d want 0", ns); else n_pass++;
    n_total++; if (bcd_time !== 16'h1300) $display("FAIL multi_bcd: got %h want 1300", bcd_time); else n_pass++;
    n_total++; if (nl != 1) $display("FAIL multi_loadn: got %0d want 1", nl); else n_pass++;
    press(10'h000, 2, -1, ns, ne, nl, lat);
    n_total++; if (ne != 1 || nl != 1) $display("FAIL zero_key: got error %0d loadn %0d want 1 1", ne, nl); else n_pass++;
  endtask

  task automatic test_sec_tens_and_clear();
    int ns, ne, nl, lat;
    logic [9:0] keys [4];
    keys[0] = 10'h001; keys[1] = 10'h001; keys[2] = 10'h080; keys[3] = 10'h001;
    do_clear();
    for (int k = 0; k < 4; k++) press(keys[k], 3, -1, ns, ne, nl, lat);
    n_total++; if (bcd_time !== 16'h0070) $display("FAIL sec70_bcd: got %h want 0070", bcd_time); else n_pass++;
    n_total++; if (time_valid !== 1'b0) $display("FAIL sec70_valid: got %b want 0", time_valid); else n_pass++;
    do_clear();
    n_total++; if (bcd_time !== 16'h0000) $display("FAIL clear_bcd: got %h want 0000", bcd_time); else n_pass++;
    n_total++; if (digit_count !== 3'd0) $display("FAIL clear_count: got %0d want 0", digit_count); else n_pass++;
    n_total++; if (time_valid !== 1'b0) $display("FAIL clear_valid: got %b want 0", time_valid); else n_pass++;
  endtask

  task automatic test_load_en_off();
    int ns, ne, nl, lat;
    load_en = 1'b0;
    press(10'h020, 3, 2, ns, ne, nl, lat);
    load_en = 1'b1;
    n_total++; if (bcd_time !== 16'h0000) $display("FAIL lden_bcd: got %h want 0000", bcd_time); else n_pass++;
    n_total++; if (ns != 0 || ne != 0) $display("FAIL lden_pulses: got strobe %0d error %0d want 0 0", ns, ne); else n_pass++;
    n_total++; if (nl != 1) $display("FAIL lden_loadn: got %0d want 1", nl); else n_pass++;
    n_total++; if (lat != 8) $display("FAIL bounce_latency: got %0d want 8", lat); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ns, ne, nl, lat;
    int seen_loadn;
    keypad = 10'h004; debounced = 1'b1;
    step(); step(); step();
    n_total++; if (bcd_time !== 16'h0002) $display("FAIL mid_pre_bcd: got %h want 0002", bcd_time); else n_pass++;
    keypad = '0; debounced = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    n_total++; if ({bcd_time, digit_count, loadn, key_strobe, key_error, time_valid} !== 23'd0)
      $display("FAIL mid_reset_outputs: got bcd %h cnt %0d flags %b want all 0",
               bcd_time, digit_count, {loadn, key_strobe, key_error, time_valid}); else n_pass++;
    rst = 1'b0;
    seen_loadn = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen_loadn += int'(loadn);
    end
    n_total++; if (seen_loadn != 0) $display("FAIL mid_no_rearm: got %0d want 0", seen_loadn); else n_pass++;
    press(10'h010, 3, -1, ns, ne, nl, lat);
    n_total++; if (bcd_time !== 16'h0004 || ns != 1) $display("FAIL mid_recover: got bcd %h strobes %0d want 0004 1", bcd_time, ns); else n_pass++;
  endtask

  task automatic test_clear_capture();
    int seen_strobe, seen_loadn;
    keypad = 10'h008; debounced = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_total++; if (bcd_time !== 16'h0000 || digit_count !== 3'd0)
      $display("FAIL clrcap_buffer: got bcd %h cnt %0d want 0000 0", bcd_time, digit_count); else n_pass++;
    n_total++; if (key_strobe !== 1'b0) $display("FAIL clrcap_strobe: got %b want 0", key_strobe); else n_pass++;
    seen_strobe = 0; seen_loadn = 0;
    step(); step();
    keypad = '0; debounced = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen_strobe += int'(key_strobe);
      seen_loadn  += int'(loadn);
    end
    n_total++; if (seen_loadn != 1 || seen_strobe != 0 || bcd_time !== 16'h0000)
      $display("FAIL clrcap_after: got loadn %0d strobe %0d bcd %h want 1 0 0000", seen_loadn, seen_strobe, bcd_time); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; keypad = '0; debounced = 1'b0; load_en = 1'b1; clear = 1'b0;
    test_reset();
    test_single_key();
    test_full_entry();
    test_key_error();
    test_sec_tens_and_clear();
    test_load_en_off();
    test_reset_mid();
    test_clear_capture();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
